// File: rtl/serdes_pkg.sv
// Shared types and helpers for the serializer/deserializer pair.
package serdes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01
    } state_t;

    // Sample-index width; a one-sample frame still needs a 1-bit counter.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serializer_ctrl.sv
// Frame sequencing for the serializer: IDLE/SEND state and the sample index.
module serializer_ctrl
    import serdes_pkg::*;
#(
    parameter  int N_SAMPLES = 8,
    localparam int CW        = cnt_width(N_SAMPLES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          recv_val,
    input  logic          send_rdy,
    output logic          recv_rdy,
    output logic          send_val,
    output logic          send_last,
    output logic          load,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] LAST_IDX = CW'(N_SAMPLES - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic          w_at_last;

    assign w_at_last = (r_count == LAST_IDX);
    assign count     = r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        case (r_state)
            IDLE: begin
                if (load) begin
                    w_state_nxt = SEND;
                    w_count_nxt = '0;
                end
            end
            SEND: begin
                if (send_rdy) begin
                    if (w_at_last) begin
                        // A frame offered on the last handshake is loaded, so stay in SEND.
                        w_count_nxt = '0;
                        if (!recv_val) begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_count_nxt = r_count + CW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    // send_rdy feeds recv_rdy combinationally so frames can abut without a bubble.
    always_comb begin
        send_val  = (r_state == SEND);
        send_last = send_val && w_at_last;
        recv_rdy  = reset && ((r_state == IDLE) || (send_last && send_rdy));
        load      = recv_val && recv_rdy;
    end

endmodule

// File: rtl/serializer.sv
// Parallel-to-serial stage: captures a whole frame, then emits it one sample per handshake.
module serializer
    import serdes_pkg::*;
#(
    parameter int N_SAMPLES = 8,
    parameter int BIT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 recv_val,
    output logic                 recv_rdy,
    input  logic [BIT_WIDTH-1:0] recv_msg [N_SAMPLES],
    output logic                 send_val,
    input  logic                 send_rdy,
    output logic [BIT_WIDTH-1:0] send_msg,
    output logic                 send_last
);

    localparam int CW = cnt_width(N_SAMPLES);

    logic                 w_load;
    logic [CW-1:0]        w_count;
    logic [BIT_WIDTH-1:0] r_buf [N_SAMPLES];

    serializer_ctrl #(
        .N_SAMPLES (N_SAMPLES)
    ) u_ctrl (
        .clk       (clk),
        .reset     (reset),
        .recv_val  (recv_val),
        .send_rdy  (send_rdy),
        .recv_rdy  (recv_rdy),
        .send_val  (send_val),
        .send_last (send_last),
        .load      (w_load),
        .count     (w_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_SAMPLES; i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_load) begin
            for (int i = 0; i < N_SAMPLES; i++) begin
                r_buf[i] <= recv_msg[i];
            end
        end
    end

    assign send_msg = send_val ? r_buf[w_count] : '0;

endmodule

// File: tb/tb_serializer.sv
// Bench for serializer: queue-based frame model, directed scenarios, then random traffic.
module tb_serializer;

    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic         rv, rr, sv, sr, sl;
    logic [W-1:0] rm [N];
    logic [W-1:0] sm;

    logic         rv1, rr1, sv1, sr1, sl1;
    logic [W-1:0] rm1 [1];
    logic [W-1:0] sm1;

    serializer #(.N_SAMPLES(N), .BIT_WIDTH(W)) u4 (
        .clk(clk), .reset(reset),
        .recv_val(rv), .recv_rdy(rr), .recv_msg(rm),
        .send_val(sv), .send_rdy(sr), .send_msg(sm), .send_last(sl)
    );

    serializer #(.N_SAMPLES(1), .BIT_WIDTH(W)) u1 (
        .clk(clk), .reset(reset),
        .recv_val(rv1), .recv_rdy(rr1), .recv_msg(rm1),
        .send_val(sv1), .send_rdy(sr1), .send_msg(sm1), .send_last(sl1)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model: samples still to be sent for the frame currently held.
    logic [W-1:0] q4[$];
    logic [W-1:0] q1[$];
    // Streams the model says were handed downstream, for literal pinning.
    logic [W-1:0] seen[$];
    bit           seen_last[$];
    logic [W-1:0] seen1[$];
    bit           seen1_last[$];
    int           acc_cyc[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Called just after a falling edge with inputs set; checks outputs, advances the model, ends on the next falling edge.
    task automatic step();
        bit e_rr, e_rr1;
        #1;
        e_rr  = reset && (q4.size() == 0 || (q4.size() == 1 && sr));
        e_rr1 = reset && (q1.size() == 0 || (q1.size() == 1 && sr1));
        chk("u4.send_val",  sv, q4.size() != 0);
        chk("u4.send_msg",  sm, (q4.size() != 0) ? q4[0] : '0);
        chk("u4.send_last", sl, q4.size() == 1);
        chk("u4.recv_rdy",  rr, e_rr);
        chk("u1.send_val",  sv1, q1.size() != 0);
        chk("u1.send_msg",  sm1, (q1.size() != 0) ? q1[0] : '0);
        chk("u1.send_last", sl1, q1.size() == 1);
        chk("u1.recv_rdy",  rr1, e_rr1);
        if (reset) begin
            if (q4.size() != 0 && sr) begin
                seen.push_back(q4[0]);
                seen_last.push_back(q4.size() == 1);
                void'(q4.pop_front());
            end
            if (rv && e_rr) begin
                for (int i = 0; i < N; i++) q4.push_back(rm[i]);
                acc_cyc.push_back(cyc);
            end
            if (q1.size() != 0 && sr1) begin
                seen1.push_back(q1[0]);
                seen1_last.push_back(q1.size() == 1);
                void'(q1.pop_front());
            end
            if (rv1 && e_rr1) q1.push_back(rm1[0]);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic set_frame(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] c, input logic [W-1:0] d);
        rm[0] = a; rm[1] = b; rm[2] = c; rm[3] = d;
    endtask

    task automatic clear_logs();
        seen.delete(); seen_last.delete(); seen1.delete(); seen1_last.delete(); acc_cyc.delete();
    endtask

    task automatic pin_stream(input string nm, input logic [W-1:0] e0, input logic [W-1:0] e1,
                              input logic [W-1:0] e2, input logic [W-1:0] e3);
        logic [W-1:0] exp_v [4];
        exp_v[0] = e0; exp_v[1] = e1; exp_v[2] = e2; exp_v[3] = e3;
        chk({nm, ".len"}, seen.size(), 4);
        for (int i = 0; i < 4 && i < seen.size(); i++) begin
            chk({nm, ".val"},  seen[i], exp_v[i]);
            chk({nm, ".last"}, seen_last[i], i == 3);
        end
    endtask

    initial begin
        reset = 1'b0;
        rv = 0; sr = 0; rv1 = 0; sr1 = 0; rm1[0] = '0;
        set_frame(8'h5A, 8'h5A, 8'h5A, 8'h5A);
        @(negedge clk);

        // Reset held: everything quiet, recv_rdy forced low.
        step(); step();
        chk("reset.recv_rdy", rr, 0);
        reset = 1'b1;
        step();

        // Single frame, recv_msg scribbled while sending.
        clear_logs();
        set_frame(8'h11, 8'h22, 8'h33, 8'h44);
        rv = 1; sr = 1;
        step();
        rv = 0;
        for (int i = 0; i < 5; i++) begin
            set_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF);
            step();
        end
        pin_stream("single", 8'h11, 8'h22, 8'h33, 8'h44);
        chk("single.idle_rdy", rr, 1);

        // Backpressure at count=1.
        clear_logs();
        set_frame(8'h11, 8'h22, 8'h33, 8'h44);
        rv = 1; sr = 1;
        step();
        rv = 0;
        step();
        sr = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp.hold_msg", sm, 8'h22);
        end
        sr = 1;
        for (int i = 0; i < 4; i++) step();
        pin_stream("bp", 8'h11, 8'h22, 8'h33, 8'h44);

        // Back-to-back frames A then B.
        clear_logs();
        set_frame(1, 2, 3, 4);
        rv = 1; sr = 1;
        step();
        set_frame(5, 6, 7, 8);
        for (int i = 0; i < 4; i++) step();
        rv = 0;
        for (int i = 0; i < 5; i++) step();
        chk("b2b.len", seen.size(), 8);
        for (int i = 0; i < 8 && i < seen.size(); i++) chk("b2b.val", seen[i], i + 1);
        chk("b2b.accepts", acc_cyc.size(), 2);
        if (acc_cyc.size() == 2) chk("b2b.gap", acc_cyc[1] - acc_cyc[0], 4);

        // Asynchronous reset at count=2.
        clear_logs();
        set_frame(8'hA0, 8'hA1, 8'hA2, 8'hA3);
        rv = 1; sr = 1;
        step();
        rv = 0;
        step(); step();
        #2;
        reset = 1'b0;
        q4.delete(); q1.delete();
        #1;
        chk("arst.send_val", sv, 0);
        chk("arst.recv_rdy", rr, 0);
        chk("arst.send_msg", sm, 0);
        @(negedge clk);
        step();
        reset = 1'b1;
        clear_logs();
        set_frame(8'hB0, 8'hB1, 8'hB2, 8'hB3);
        rv = 1;
        step();
        rv = 0;
        for (int i = 0; i < 5; i++) step();
        pin_stream("arst", 8'hB0, 8'hB1, 8'hB2, 8'hB3);

        // One-sample frames offered continuously.
        clear_logs();
        rv1 = 1; sr1 = 1;
        rm1[0] = 8'h0A; step();
        rm1[0] = 8'h0B; step();
        rm1[0] = 8'h0C; step();
        rv1 = 0;
        step(); step();
        chk("n1.len", seen1.size(), 3);
        for (int i = 0; i < 3 && i < seen1.size(); i++) begin
            chk("n1.val",  seen1[i], 8'h0A + i);
            chk("n1.last", seen1_last[i], 1);
        end

        // Random traffic with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            rv  = ($urandom_range(0, 2) == 0);
            sr  = ($urandom_range(0, 3) != 0);
            rv1 = ($urandom_range(0, 1) == 0);
            sr1 = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) rm[i] = W'($urandom);
            rm1[0] = W'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b0;
                q4.delete(); q1.delete();
                step();
                reset = 1'b1;
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
